serial_subtractor: RTL and testbench

Multi-cycle, parametrised successor to the single-bit half subtractor. It computes a - b - borr_in over WIDTH bits, processing STEP bits per clock through a registered borrow chain. Operands are taken in with a valid/ready handshake, and the result is returned with a valid/ready handshake. It is the arithmetic building block for narrow-datapath designs that trade latency for area.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_sub_slice.sv | 24 ++
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the slice-counter width calculation.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nslice);
    int w;
    w = $clog2(nslice);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational STEP-bit subtract slice: d_s = a_s - b_s - bin, with borrow out.
// Built as a ripple of single-bit full subtractors.
module sub_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a_s,
  input  logic [STEP-1:0] b_s,
  input  logic            bin,
  output logic [STEP-1:0] d_s,
  output logic            bout
);

  logic [STEP:0] bw;

  assign bw[0] = bin;

  for (genvar i = 0; i < STEP; i++) begin : g_bit
    assign d_s[i]   = a_s[i] ^ b_s[i] ^ bw[i];
    assign bw[i+1]  = (~a_s[i] & b_s[i]) | (~(a_s[i] ^ b_s[i]) & bw[i]);
  end

  assign bout = bw[STEP];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - borr_in over WIDTH bits, STEP bits per clock,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borr_out,
  output logic             zero
);

  localparam int NSLICE = WIDTH / STEP;
  localparam int CW     = cnt_width(NSLICE);

  if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_chk
    $fatal(1, "serial_subtractor: STEP must be >= 1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borr_q, borr_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] diff_q;
  logic             borr_out_q, zero_q;

  logic [STEP-1:0]  d_s;
  logic             bout;
  logic [WIDTH-1:0] res_shift;
  logic             last_slice;
  logic             accept;
  logic             load_result;

  sub_slice #(.STEP(STEP)) u_slice (
    .a_s  (a_q[STEP-1:0]),
    .b_s  (b_q[STEP-1:0]),
    .bin  (borr_q),
    .d_s  (d_s),
    .bout (bout)
  );

  // New slice enters at the MSB; after NSLICE shifts the register holds the full difference.
  assign res_shift  = WIDTH'({d_s, res_q} >> STEP);
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    borr_d      = borr_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          borr_d  = borr_in;
          state_d = RUN;
        end
      end
      RUN: begin
        borr_d = bout;
        cnt_d  = cnt_q + CW'(1);
        if (last_slice) begin
          load_result = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers: cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      borr_q     <= 1'b0;
      diff_q     <= '0;
      borr_out_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      borr_q  <= borr_d;
      if (load_result) begin
        diff_q     <= res_shift;
        borr_out_q <= bout;
        zero_q     <= (res_shift == '0);
      end
    end
  end

  // Operand and partial-result shift registers: always rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> STEP;
      b_q   <= b_q >> STEP;
      res_q <= res_shift;
    end
  end

  assign diff     = diff_q;
  assign borr_out = borr_out_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: two instances (8x1 and 16x4),
// drivers push model results into queues, monitors pop and compare.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bo;
    logic        z;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   prob = 100;
  bit   hold8 = 1'b0;

  logic       iv8 = 1'b0, bi8 = 1'b0, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       rdy8, ov8, bo8, z8;
  logic [7:0] do8;

  logic        iv16 = 1'b0, bi16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, ov16, bo16, z16;
  logic [15:0] do16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t cur8, cur16;
  bit   seen8 = 1'b0, seen16 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8), .STEP(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
    .a(a8), .b(b8), .borr_in(bi8), .out_valid(ov8), .out_ready(or8),
    .diff(do8), .borr_out(bo8), .zero(z8)
  );

  serial_subtractor #(.WIDTH(16), .STEP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
    .a(a16), .b(b16), .borr_in(bi16), .out_valid(ov16), .out_ready(or16),
    .diff(do16), .borr_out(bo16), .zero(z16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: plain integer subtraction, wrapped into w bits.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bi);
    exp_t e;
    int   r;
    r      = int'(a) - int'(b) - int'(bi);
    e.bo   = (r < 0);
    e.diff = 16'((r + (1 << w)) % (1 << w));
    e.z    = (e.diff == 16'd0);
    e.acc  = 0;
    return e;
  endfunction

  task automatic send(input bit w16, input logic [15:0] a, input logic [15:0] b, input logic bi);
    exp_t e;
    int   t;
    e = model(w16 ? 16 : 8, a, b, bi);
    @(negedge clk);
    if (w16) begin iv16 = 1'b1; a16 = a; b16 = b; bi16 = bi; end
    else     begin iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; bi8 = bi; end
    t = 0;
    while (!(w16 ? rdy16 : rdy8) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now(w16 ? "accept16" : "accept8");
    else begin
      e.acc = cyc + 1;
      if (w16) q16.push_back(e); else q8.push_back(e);
      @(negedge clk);
    end
    if (w16) iv16 = 1'b0; else iv8 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() != 0 || q16.size() != 0 || ov8 || ov16) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail_now("drain");
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen8 = 1'b0;
        or8   = 1'b0;
      end else begin
        if (ov8) begin
          if (!seen8) begin
            if (q8.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL out8_unexpected: got diff=%0h, expected no result", do8);
            end else begin
              cur8 = q8.pop_front();
              chk("diff8", 32'(do8), 32'(cur8.diff));
              chk("borr8", 32'(bo8), 32'(cur8.bo));
              chk("zero8", 32'(z8), 32'(cur8.z));
              chk("lat8", 32'(cyc - cur8.acc), 32'd8);
            end
            seen8 = 1'b1;
          end else begin
            chk("hold8", 32'(do8), 32'(cur8.diff));
          end
        end
        or8 = !hold8 && ($urandom_range(0, 99) < prob);
        if (ov8 && or8) seen8 = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen16 = 1'b0;
        or16   = 1'b0;
      end else begin
        if (ov16) begin
          if (!seen16) begin
            if (q16.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL out16_unexpected: got diff=%0h, expected no result", do16);
            end else begin
              cur16 = q16.pop_front();
              chk("diff16", 32'(do16), 32'(cur16.diff));
              chk("borr16", 32'(bo16), 32'(cur16.bo));
              chk("zero16", 32'(z16), 32'(cur16.z));
              chk("lat16", 32'(cyc - cur16.acc), 32'd4);
            end
            seen16 = 1'b1;
          end else begin
            chk("hold16", 32'(do16), 32'(cur16.diff));
          end
        end
        or16 = ($urandom_range(0, 99) < prob);
        if (ov16 && or16) seen16 = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready8", 32'(rdy8), 32'd0);
    chk("rst_ready16", 32'(rdy16), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_diff8", 32'(do8), 32'd0);
    chk("rst_valid8", 32'(ov8), 32'd0);
    chk("rst_flags16", 32'({bo16, z16, ov16}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready8", 32'(rdy8), 32'd1);

    send(1'b0, 16'h05, 16'h03, 1'b0);
    send(1'b0, 16'h03, 16'h05, 1'b0);
    send(1'b0, 16'h00, 16'h00, 1'b1);
    send(1'b0, 16'h7A, 16'h7A, 1'b0);
    send(1'b1, 16'h1234, 16'h0235, 1'b0);
    drain();

    // Backpressure: hold the 8-bit result and poke in_valid while stalled.
    hold8 = 1'b1;
    send(1'b0, 16'h05, 16'h03, 1'b0);
    begin
      int t;
      t = 0;
      while (!ov8 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) fail_now("bp_wait");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov8), 32'd1);
      chk("bp_ready", 32'(rdy8), 32'd0);
      chk("bp_diff", 32'(do8), 32'h02);
      iv8 = (i % 2 == 0);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    hold8 = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(ov8), 32'd0);
    chk("bp_release_ready", 32'(rdy8), 32'd1);

    // Reset during RUN discards the operation.
    send(1'b0, 16'h40, 16'h11, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q8.delete();
    chk("mid_rst_diff", 32'(do8), 32'd0);
    chk("mid_rst_flags", 32'({bo8, z8, ov8, rdy8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(rdy8), 32'd1);
    send(1'b0, 16'h10, 16'h01, 1'b0);
    drain();

    prob = 70;
    fork
      for (int i = 0; i < 200; i++)
        send(1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
      for (int j = 0; j < 1000; j++)
        send(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
